output_layer_collector: RTL and testbench
=========================================

Name: output_layer_collector

Overview:
- Sits directly upstream of the 10-way sign-magnitude argmax stage.
- Accepts the output-layer neuron accumulators from the MAC array one at a time over a valid/ready handshake.
- Rescales and saturates each accumulator, converts it to 16-bit sign-magnitude, and packs it into a 160-bit frame buffer.
- Presents the complete frame to the argmax with a valid/ready handshake, so that argmax index k equals neuron k.

Parameters:
- N_OUT, 10: neurons per frame; out_data width is N_OUT*DATA_W; counter width is 4.
- DATA_W, 16: sign-magnitude word width (1 sign bit, 15 magnitude bits).
- ACC_W, 32: two's-complement accumulator width from the MAC array.
- FRAC_SHIFT, 8: arithmetic right shift applied to each accumulator before saturation.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- rst, input, 1: asynchronous active-high reset.
- start, input, 1: one-cycle pulse; clears the buffer and opens a new frame.
- in_valid, input, 1: in_data holds a valid accumulator.
- in_ready, output, 1: collector can accept a word this cycle.
- in_data, input, ACC_W: signed accumulator of neuron cnt.
- out_valid, output, 1: out_data holds a complete frame.
- out_ready, input, 1: downstream consumes the frame.
- out_data, output, N_OUT*DATA_W: packed frame; neuron k occupies bits [(N_OUT-1-k)*16+15 -: 16].
- busy, output, 1: high in COLLECT or FULL.
- cnt_o, output, 4: number of words accepted in the current frame.

Behaviour:
- Reset (async, rst=1):
  - state is IDLE; cnt is 0; buffer is all 0.
  - in_ready, out_valid, busy and cnt_o are all 0.
- States:
  - IDLE: in_ready=0. start moves to COLLECT with cnt=0 and the buffer cleared.
  - COLLECT: in_ready=1. Each cycle with in_valid&in_ready stores the converted word in slot cnt and increments cnt. The accept that makes cnt reach N_OUT moves to FULL on the same edge.
  - FULL: in_ready=0; out_valid=1; out_data is stable. out_valid&out_ready returns to IDLE next edge; the buffer contents are kept; out_valid drops.
- Latency: out_valid rises on the clock edge of the 10th accept, so it is visible the cycle after the 10th handshake. Throughput is one word per cycle.
- Conversion, registered at accept:
  - s = in_data >>> FRAC_SHIFT (sign-preserving).
  - s > 32767 gives 16'h7FFF.
  - s < -32767 gives 16'hFFFF.
  - s < 0 gives {1'b1, (-s)[14:0]}.
  - Otherwise gives {1'b0, s[14:0]}.
- 16'h8000 (negative zero) is reserved downstream as a special code and is never produced; s = 0 always gives 16'h0000.
- start has priority over everything except rst:
  - In COLLECT it aborts the frame and restarts: cnt=0, buffer cleared, state stays COLLECT. Any word handshaken in that same cycle is discarded.
  - In FULL it drops out_valid and restarts collection; the frame is lost.
- in_valid in IDLE or FULL is ignored; no handshake occurs because in_ready=0.
- out_ready while out_valid=0 has no effect.
- busy = (state != IDLE). cnt_o = cnt.
- rst mid-frame returns to the reset state immediately; the partial frame is discarded.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, COLLECT=2'd1, FULL=2'd2);
  - the constants SM_NEG_ZERO=16'h8000, SM_POS_MAX=16'h7FFF, SM_NEG_MAX=16'hFFFF;
  - N_OUT and DATA_W defaults.
- One natural sub-module, acc_to_sign_mag: combinational shift, saturation and two's-complement-to-sign-magnitude conversion, parameterised by ACC_W and FRAC_SHIFT. It is reused by any later layer needing the same format.

Test Plan:
- Reset, then start, then 10 back-to-back words with in_data = k<<8 (k=0..9). Expect:
  - out_valid rises the cycle after the 10th handshake;
  - neuron k slot = 16'h000k;
  - bits[15:0] = 16'h0009;
  - bits[159:144] = 16'h0000;
  - downstream index for the max equals 9.
- Saturation and sign words: in_data = 32'h7FFFFFFF gives 16'h7FFF; 32'h80000000 gives 16'hFFFF; 32'hFFFFFF00 (-256) gives 16'h8001; 32'h000000FF (s=0) gives 16'h0000, never 16'h8000.
- Backpressure: hold out_ready=0 for 5 cycles in FULL. Expect:
  - out_data stable; in_ready=0; extra in_valid words are not accepted.
  - out_ready=1 for one cycle moves to IDLE next edge with out_valid=0.
- Abort: start pulsed after 4 accepts, coincident with a 5th in_valid. Expect:
  - cnt_o=0 and the buffer is all zero;
  - the 5th word is discarded;
  - the new frame of 10 words completes normally.
- Async reset asserted mid-cycle during COLLECT (cnt=6). Expect:
  - all outputs are 0 immediately, without waiting for clk;
  - after release, state is IDLE and in_ready=0 until start.
- Gapped input: in_valid toggled pseudo-randomly over 10 words. Expect:
  - slot order matches acceptance order;
  - cnt_o increments only on handshakes.

Source files
------------

// File: rtl/output_layer_collector_pkg.sv
// Shared types and constants for the output-layer collector and its converter.
package output_layer_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  localparam logic [15:0] SM_NEG_ZERO = 16'h8000;  // reserved downstream, never produced
  localparam logic [15:0] SM_POS_MAX  = 16'h7FFF;
  localparam logic [15:0] SM_NEG_MAX  = 16'hFFFF;

  localparam int unsigned N_OUT_DEFAULT  = 10;
  localparam int unsigned DATA_W_DEFAULT = 16;

endpackage

// File: rtl/output_layer_collector_acc_to_sign_mag.sv
// Combinational rescale, saturate and two's-complement to sign-magnitude conversion.
module acc_to_sign_mag
  import output_layer_collector_pkg::*;
#(
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned FRAC_SHIFT = 8
) (
  input  logic [ACC_W-1:0]          acc,
  output logic [DATA_W_DEFAULT-1:0] sm
);

  localparam int unsigned MAG_W = DATA_W_DEFAULT - 1;
  localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'((1 << MAG_W) - 1);
  localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;

  logic signed [ACC_W-1:0] s;

  // Clamp to +/-(2^15-1) so the magnitude always fits and -0 cannot appear.
  always_comb begin
    s = $signed(acc) >>> FRAC_SHIFT;
    if (s > POS_LIM)
      sm = SM_POS_MAX;
    else if (s < NEG_LIM)
      sm = SM_NEG_MAX;
    else if (s < 0)
      sm = {1'b1, MAG_W'(-s)};
    else
      sm = {1'b0, MAG_W'(s)};
  end

endmodule

// File: rtl/output_layer_collector.sv
// Collects N_OUT converted neuron words into a frame for the argmax stage.
module output_layer_collector
  import output_layer_collector_pkg::*;
#(
  parameter int unsigned N_OUT      = N_OUT_DEFAULT,
  parameter int unsigned DATA_W     = DATA_W_DEFAULT,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned FRAC_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ACC_W-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    busy,
  output logic [3:0]              cnt_o
);

  localparam int unsigned CNT_W = 4;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N_OUT*DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0]       word;
  logic                    accept;

  acc_to_sign_mag #(
    .ACC_W      (ACC_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_conv (
    .acc (in_data),
    .sm  (word)
  );

  assign in_ready  = (state_q == ST_COLLECT);
  assign out_valid = (state_q == ST_FULL);
  assign busy      = (state_q != ST_IDLE);
  assign cnt_o     = cnt_q;
  assign out_data  = buf_q;
  assign accept    = in_valid & in_ready;

  // Next-state: start overrides any handshake; neuron k lands in slot k (MSB-first).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    if (start) begin
      state_d = ST_COLLECT;
      cnt_d   = '0;
      buf_d   = '0;
    end else begin
      unique case (state_q)
        ST_COLLECT: begin
          if (accept) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
              if (cnt_q == CNT_W'(k))
                buf_d[(N_OUT-1-k)*DATA_W +: DATA_W] = word;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N_OUT-1))
              state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready)
            state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  // State, count and frame buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_output_layer_collector.sv
// Directed self-checking bench for output_layer_collector.
module tb_output_layer_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [159:0] out_data;
  logic         busy;
  logic [3:0]   cnt_o;

  int n_vec = 0;
  int n_err = 0;

  output_layer_collector #(
    .N_OUT      (10),
    .DATA_W     (16),
    .ACC_W      (32),
    .FRAC_SHIFT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .cnt_o     (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] slot(input logic [159:0] f, input int k);
    return f[(9-k)*16 +: 16];
  endfunction

  function automatic int argmax(input logic [159:0] f);
    int best_i = 0;
    int best_v = -100000;
    for (int k = 0; k < 10; k++) begin
      logic [15:0] w;
      int v;
      w = slot(f, k);
      v = w[15] ? -int'(w[14:0]) : int'(w[14:0]);
      if (v > best_v) begin
        best_v = v;
        best_i = k;
      end
    end
    return best_i;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [31:0]  sat_in  [10] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFF00, 32'h000000FF, 32'h007FFF00,
                                 32'h00800000, 32'hFF800100, 32'hFFFFFEFF, 32'hFFFFFFFF, 32'h00012300};
  logic [15:0]  sat_exp [10] = '{16'h7FFF, 16'hFFFF, 16'h8001, 16'h0000, 16'h7FFF,
                                 16'h7FFF, 16'hFFFF, 16'h8002, 16'h8001, 16'h0123};
  logic [159:0] exp_f;
  logic [31:0]  gap_pat;
  int           nacc;
  int           budget;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", cnt_o, 0);
    check("rst_data", out_data, 0);
    step();
    rst = 1'b0;
    step();

    // Frame 1: in_data = k<<8 back to back.
    pulse_start();
    check("f1_busy", busy, 1);
    check("f1_in_ready", in_ready, 1);
    check("f1_cnt0", cnt_o, 0);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(k) << 8;
      step();
      check($sformatf("f1_cnt%0d", k), cnt_o, 160'(k + 1));
      check($sformatf("f1_ov%0d", k), out_valid, (k == 9) ? 1 : 0);
    end
    in_valid = 1'b0;
    check("f1_frame", out_data, 160'h0000_0001_0002_0003_0004_0005_0006_0007_0008_0009);
    check("f1_low", out_data[15:0], 16'h0009);
    check("f1_high", out_data[159:144], 16'h0000);
    check("f1_argmax", argmax(out_data), 9);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("f1_drain_ov", out_valid, 0);
    check("f1_drain_busy", busy, 0);
    check("f1_kept", out_data[15:0], 16'h0009);

    // out_ready in IDLE has no effect.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_ready_busy", busy, 0);
    check("idle_ready_ov", out_valid, 0);

    // Saturation / sign frame, then backpressure.
    pulse_start();
    exp_f = '0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = sat_in[k];
      exp_f[(9-k)*16 +: 16] = sat_exp[k];
      step();
    end
    check("sat_ov", out_valid, 1);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("sat_slot%0d", k), slot(out_data, k), sat_exp[k]);
      check($sformatf("sat_nz%0d", k), slot(out_data, k) == 16'h8000, 0);
    end
    in_data = 32'h12345678;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp_data%0d", c), out_data, exp_f);
      check($sformatf("bp_in_ready%0d", c), in_ready, 0);
      check($sformatf("bp_ov%0d", c), out_valid, 1);
      check($sformatf("bp_cnt%0d", c), cnt_o, 10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_drain_ov", out_valid, 0);
    check("bp_drain_busy", busy, 0);
    check("bp_kept", out_data, exp_f);

    // Abort after 4 accepts with a coincident 5th word.
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(k + 1) << 8;
      step();
    end
    check("ab_cnt4", cnt_o, 4);
    start    = 1'b1;
    in_data  = 32'h00005500;
    step();
    start    = 1'b0;
    check("ab_cnt0", cnt_o, 0);
    check("ab_clear", out_data, 0);
    check("ab_busy", busy, 1);
    for (int k = 0; k < 10; k++) begin
      in_data = 32'(k + 16) << 8;
      step();
    end
    in_valid = 1'b0;
    check("ab_ov", out_valid, 1);
    check("ab_frame", out_data, 160'h0010_0011_0012_0013_0014_0015_0016_0017_0018_0019);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Async reset mid-cycle at cnt=6.
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(k + 1) << 8;
      step();
    end
    check("ar_cnt6", cnt_o, 6);
    #2;
    rst = 1'b1;
    #1;
    check("ar_in_ready", in_ready, 0);
    check("ar_ov", out_valid, 0);
    check("ar_busy", busy, 0);
    check("ar_cnt", cnt_o, 0);
    check("ar_data", out_data, 0);
    step();
    rst = 1'b0;
    step();
    step();
    check("ar_post_in_ready", in_ready, 0);
    check("ar_post_busy", busy, 0);
    check("ar_post_cnt", cnt_o, 0);
    in_valid = 1'b0;

    // Gapped input with a fixed valid pattern.
    gap_pat = 32'hB5A3_9C6D;
    pulse_start();
    nacc   = 0;
    budget = 0;
    while (nacc < 10 && budget < 100) begin
      in_valid = gap_pat[budget % 32];
      in_data  = 32'(nacc + 'h30) << 8;
      step();
      if (in_valid) nacc++;
      check($sformatf("gap_cnt%0d", budget), cnt_o, 160'(nacc));
      budget++;
    end
    in_valid = 1'b0;
    check("gap_budget", nacc, 10);
    check("gap_ov", out_valid, 1);
    check("gap_frame", out_data, 160'h0030_0031_0032_0033_0034_0035_0036_0037_0038_0039);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("gap_drain_ov", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
